// File: rtl/barrel_pkg.sv
// Shared definitions for the barrel rotator sequencer: default sizes and FSM state encoding.
package barrel_pkg;

   localparam int DATA_SIZE_DEF = 8;
   localparam int SEL_W_DEF     = 3;
   localparam int AMT_W_DEF     = 5;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      SHIFT = 2'd2,
      DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/barrel_arbiter_seq_if.sv
// Command, result and rotator-control bundle between the sequencer and its environment.
interface barrel_arbiter_seq_if #(
   parameter int DATA_SIZE = barrel_pkg::DATA_SIZE_DEF,
   parameter int SEL_W     = barrel_pkg::SEL_W_DEF,
   parameter int AMT_W     = barrel_pkg::AMT_W_DEF
);

   logic                 req0_valid;
   logic                 req0_ready;
   logic [DATA_SIZE-1:0] req0_data;
   logic [AMT_W-1:0]     req0_amt;

   logic                 req1_valid;
   logic                 req1_ready;
   logic [DATA_SIZE-1:0] req1_data;
   logic [AMT_W-1:0]     req1_amt;

   logic                 res_valid;
   logic                 res_ready;
   logic [DATA_SIZE-1:0] res_data;
   logic                 res_id;

   logic                 brl_load;
   logic [SEL_W-1:0]     brl_sel;
   logic [DATA_SIZE-1:0] brl_data_in;
   logic [DATA_SIZE-1:0] brl_data_out;

   modport slave (
      input  req0_valid, req0_data, req0_amt,
      input  req1_valid, req1_data, req1_amt,
      input  res_ready, brl_data_out,
      output req0_ready, req1_ready,
      output res_valid, res_data, res_id,
      output brl_load, brl_sel, brl_data_in
   );

   modport master (
      output req0_valid, req0_data, req0_amt,
      output req1_valid, req1_data, req1_amt,
      output res_ready, brl_data_out,
      input  req0_ready, req1_ready,
      input  res_valid, res_data, res_id,
      input  brl_load, brl_sel, brl_data_in
   );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: a lone requester always wins, on contention the one not granted last wins.
module rr_arb2 (
   input  logic [1:0] valid,
   input  logic       last_grant,
   output logic       grant_valid,
   output logic       grant_id
);

   always_comb begin
      grant_valid = |valid;
      grant_id    = 1'b0;
      case (valid)
         2'b01:   grant_id = 1'b0;
         2'b10:   grant_id = 1'b1;
         2'b11:   grant_id = ~last_grant;
         default: grant_id = 1'b0;
      endcase
   end

endmodule

// File: rtl/barrel_arbiter_seq.sv
// Arbitrates two rotate requesters onto a shared registered rotator, splitting large
// rotate amounts into passes of at most DATA_SIZE-1 positions.
//
// state | meaning
// IDLE  | waiting for a command; grant and capture happen here
// LOAD  | operand loaded into the rotator, remaining amount initialised
// SHIFT | one rotate pass per cycle until the remaining amount is exhausted
// DONE  | result presented until the consumer accepts it
module barrel_arbiter_seq #(
   parameter int DATA_SIZE = barrel_pkg::DATA_SIZE_DEF,
   parameter int SEL_W     = barrel_pkg::SEL_W_DEF,
   parameter int AMT_W     = barrel_pkg::AMT_W_DEF
) (
   input  logic                 clk,
   input  logic                 reset,
   barrel_arbiter_seq_if.slave  bus,
   output logic                 busy
);

   import barrel_pkg::*;

   localparam logic [AMT_W-1:0] MAX_PASS = AMT_W'(DATA_SIZE - 1);

   state_t               state_q;
   state_t               state_d;
   logic                 last_grant_q;
   logic [DATA_SIZE-1:0] op_data_q;
   logic [AMT_W-1:0]     op_amt_q;
   logic                 op_id_q;
   logic [AMT_W-1:0]     rem_q;

   logic                 grant_valid;
   logic                 grant_id;
   logic                 accept;
   logic [AMT_W-1:0]     pass_amt;
   logic [AMT_W-1:0]     rem_after;

   rr_arb2 u_arb (
      .valid       ({bus.req1_valid, bus.req0_valid}),
      .last_grant  (last_grant_q),
      .grant_valid (grant_valid),
      .grant_id    (grant_id)
   );

   assign pass_amt  = (rem_q > MAX_PASS) ? MAX_PASS : rem_q;
   assign rem_after = rem_q - pass_amt;
   assign busy      = (state_q != IDLE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;
         op_data_q    <= '0;
         op_amt_q     <= '0;
         op_id_q      <= 1'b0;
         rem_q        <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            op_data_q    <= grant_id ? bus.req1_data : bus.req0_data;
            op_amt_q     <= grant_id ? bus.req1_amt  : bus.req0_amt;
            op_id_q      <= grant_id;
            last_grant_q <= grant_id;
         end
         if (state_q == LOAD) begin
            rem_q <= op_amt_q;
         end else if (state_q == SHIFT) begin
            rem_q <= rem_after;
         end
      end
   end

   always_comb begin
      state_d         = state_q;
      accept          = 1'b0;
      bus.req0_ready  = 1'b0;
      bus.req1_ready  = 1'b0;
      bus.brl_load    = 1'b0;
      bus.brl_sel     = '0;
      bus.brl_data_in = '0;
      bus.res_valid   = 1'b0;
      bus.res_data    = '0;
      bus.res_id      = 1'b0;
      case (state_q)
         IDLE: begin
            // Ready is suppressed during reset so no command is taken while the block is held.
            if (!reset && grant_valid) begin
               accept         = 1'b1;
               bus.req0_ready = ~grant_id;
               bus.req1_ready = grant_id;
               state_d        = LOAD;
            end
         end
         LOAD: begin
            bus.brl_load    = 1'b1;
            bus.brl_data_in = op_data_q;
            state_d         = (op_amt_q != '0) ? SHIFT : DONE;
         end
         SHIFT: begin
            bus.brl_sel = pass_amt[SEL_W-1:0];
            state_d     = (rem_after != '0) ? SHIFT : DONE;
         end
         DONE: begin
            bus.res_valid = 1'b1;
            bus.res_data  = bus.brl_data_out;
            bus.res_id    = op_id_q;
            if (bus.res_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

endmodule
